// File: rtl/kbd_fifo_if.sv
// rtl/kbd_fifo_if.sv - keyboard scancode FIFO bus bundle
//
// Purpose: groups the byte-in strobe, pop strobe and head-entry outputs of
//          kbd_fifo so they travel as one port.
// Ports (signals):
//   ps2_data [7:0]   received scancode byte
//   ps2_hit          one-cycle strobe, ps2_data valid
//   rd               one-cycle pop strobe
//   ovf_clr          one-cycle strobe, clears overflow
//   q [7:0]          head-entry scancode
//   q_ext            head entry was E0-prefixed
//   q_rel            head entry was F0-prefixed
//   empty            FIFO holds no entries
//   count [CW-1:0]   entries held, 0..DEPTH
//   overflow         sticky drop indicator
// Modports: master drives bytes/pops, slave is the FIFO.

interface kbd_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    ps2_data;
  logic          ps2_hit;
  logic          rd;
  logic          ovf_clr;
  logic [7:0]    q;
  logic          q_ext;
  logic          q_rel;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output ps2_data, ps2_hit, rd, ovf_clr,
    input  q, q_ext, q_rel, empty, count, overflow
  );

  modport slave (
    input  ps2_data, ps2_hit, rd, ovf_clr,
    output q, q_ext, q_rel, empty, count, overflow
  );
endinterface

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - PS/2 scancode prefix folder and first-word-fall-through FIFO
//
// Purpose: folds E0/F0 prefix bytes into ext/rel flags on the following code,
//          discards a dangling prefix after PREFIX_TIMEOUT clocks, and queues
//          completed {ext,rel,code} entries in a DEPTH-entry FWFT FIFO.
// Optional feature macro: KBD_FIFO_TYPEMATIC_FILTER_EN
//   defined   -> repeated make codes of a still-held key are suppressed
//   undefined -> every completed entry is queued
// Ports:
//   clock            system clock
//   reset            synchronous, active-high
//   bus (slave)      kbd_fifo_if: ps2_data/ps2_hit in, rd/ovf_clr in,
//                    q/q_ext/q_rel/empty/count/overflow out

module kbd_fifo #(
  parameter int DEPTH          = 16,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input logic       clock,
  input logic       reset,
  kbd_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT) + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_E0     = 2'd1;
  localparam logic [1:0] ST_F0     = 2'd2;
  localparam logic [1:0] ST_E0F0   = 2'd3;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [DEPTH];

  logic          push_req;
  logic          ent_ext;
  logic          ent_rel;
  logic          suppress;
  logic          push_ok;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;
  logic [9:0]    head;

  // Prefix FSM: only a received byte moves it, except for the timeout
  // which quietly returns a stale prefix state to IDLE.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    push_req = 1'b0;
    ent_ext  = 1'b0;
    ent_rel  = 1'b0;
    if (bus.ps2_hit) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ps2_data == CODE_E0)      state_d = ST_E0;
          else if (bus.ps2_data == CODE_F0) state_d = ST_F0;
          else                              push_req = 1'b1;
        end
        ST_E0: begin
          if (bus.ps2_data == CODE_F0) begin
            state_d = ST_E0F0;
          end else if (bus.ps2_data != CODE_E0) begin
            push_req = 1'b1;
            ent_ext  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_F0: begin
          push_req = 1'b1;
          ent_rel  = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          push_req = 1'b1;
          ent_ext  = 1'b1;
          ent_rel  = 1'b1;
          state_d  = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

`ifdef KBD_FIFO_TYPEMATIC_FILTER_EN
  logic [8:0] last_make_q, last_make_d;
  logic       held_q, held_d;
  logic [8:0] ent_key;

  assign ent_key  = {ent_ext, bus.ps2_data};
  assign suppress = push_req && !ent_rel && held_q && (ent_key == last_make_q);

  always_comb begin
    last_make_d = last_make_q;
    held_d      = held_q;
    if (push_req && !suppress) begin
      if (!ent_rel) begin
        last_make_d = ent_key;
        held_d      = 1'b1;
      end else if (ent_key == last_make_q) begin
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_make_q <= '0;
      held_q      <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      held_q      <= held_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign push_ok = push_req && !suppress;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = bus.rd && !empty;
  // A full FIFO still accepts a push when a pop frees the head slot.
  assign do_push = push_ok && (!full || pop);
  assign drop    = push_ok && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Setting wins over a same-cycle clear.
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= {ent_ext, ent_rel, bus.ps2_data};
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.q        = empty ? 8'h00 : head[7:0];
  assign bus.q_ext    = empty ? 1'b0  : head[9];
  assign bus.q_rel    = empty ? 1'b0  : head[8];
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// tb/tb_kbd_fifo.sv - directed self-checking bench for kbd_fifo

module tb_kbd_fifo;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  kbd_fifo_if #(.DEPTH(16)) bus ();

  kbd_fifo #(.DEPTH(16), .PREFIX_TIMEOUT(50000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    bus.ps2_data = b;
    bus.ps2_hit  = 1'b1;
    @(posedge clock); #1;
    bus.ps2_hit  = 1'b0;
  endtask

  task automatic pop1();
    bus.rd = 1'b1;
    @(posedge clock); #1;
    bus.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", bus.overflow); end
    checks++; if ({bus.q_ext, bus.q_rel, bus.q} !== 10'h000) begin errors++; $display("FAIL reset_q got %h want 000", {bus.q_ext, bus.q_rel, bus.q}); end
    reset = 1'b0;
    // Reset mid-prefix must forget the E0.
    send(8'hE0);
    do_reset();
    send(8'h1C);
    checks++; if ({bus.q_ext, bus.q_rel, bus.q} !== {2'b00, 8'h1C}) begin errors++; $display("FAIL reset_prefix got %h want 01c", {bus.q_ext, bus.q_rel, bus.q}); end
    do_reset();
  endtask

  task automatic test_single();
    send(8'h1C);
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_empty got %0b want 0", bus.empty); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.count); end
    checks++; if ({bus.q_ext, bus.q_rel, bus.q} !== {2'b00, 8'h1C}) begin errors++; $display("FAIL single_q got %h want 01c", {bus.q_ext, bus.q_rel, bus.q}); end
    pop1();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %0b want 1", bus.empty); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", bus.count); end
  endtask

  task automatic test_prefix();
    send(8'hE0);
    send(8'hF0);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL prefix_pending_count got %0d want 0", bus.count); end
    send(8'h74);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL prefix_e0f0_count got %0d want 1", bus.count); end
    checks++; if ({bus.q_ext, bus.q_rel, bus.q} !== {2'b11, 8'h74}) begin errors++; $display("FAIL prefix_e0f0_q got %h want 374", {bus.q_ext, bus.q_rel, bus.q}); end
    pop1();
    send(8'hE0); send(8'hE0); send(8'h75);
    checks++; if ({bus.count, bus.q_ext, bus.q_rel, bus.q} !== {5'd1, 2'b10, 8'h75}) begin errors++; $display("FAIL prefix_e0e0 got cnt %0d entry %h want cnt 1 entry 275", bus.count, {bus.q_ext, bus.q_rel, bus.q}); end
    pop1();
    send(8'hF0); send(8'hE0);
    checks++; if ({bus.count, bus.q_ext, bus.q_rel, bus.q} !== {5'd1, 2'b01, 8'hE0}) begin errors++; $display("FAIL prefix_f0e0 got cnt %0d entry %h want cnt 1 entry 1e0", bus.count, {bus.q_ext, bus.q_rel, bus.q}); end
    pop1();
  endtask

  task automatic test_order();
    logic [7:0] exp_q;
    do_reset();
    for (int i = 0; i < 10; i++) send(8'h20 + 8'(i));
    exp_q = 8'h20;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL order_a got %h want %h", bus.q, exp_q); end
      pop1();
      exp_q = exp_q + 8'h01;
    end
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL order_count got %0d want 15", bus.count); end
    for (int i = 0; i < 15; i++) begin
      exp_q = (i < 5) ? 8'h25 + 8'(i) : 8'h30 + 8'(i - 5);
      checks++; if (bus.q !== exp_q) begin errors++; $display("FAIL order_b got %h want %h", bus.q, exp_q); end
      pop1();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_drained got %0b want 1", bus.empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h15);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", bus.overflow); end
    bus.ovf_clr = 1'b1; idle(1); bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", bus.overflow); end
    // Full push with simultaneous pop.
    bus.ps2_data = 8'h15; bus.ps2_hit = 1'b1; bus.rd = 1'b1;
    idle(1);
    bus.ps2_hit = 1'b0; bus.rd = 1'b0;
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_pushpop_count got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pushpop_flag got %0b want 0", bus.overflow); end
    // Dropped push and clear together: set wins.
    bus.ps2_data = 8'h16; bus.ps2_hit = 1'b1; bus.ovf_clr = 1'b1;
    idle(1);
    bus.ps2_hit = 1'b0; bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_prio got %0b want 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_drop_count got %0d want 16", bus.count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.q !== 8'h15) begin errors++; $display("FAIL ovf_drain got %h want 15", bus.q); end
      pop1();
    end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_empty_edge();
    pop1();
    checks++; if ({bus.empty, bus.count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL rd_empty got empty %0b cnt %0d want 1 0", bus.empty, bus.count); end
    bus.ps2_data = 8'h33; bus.ps2_hit = 1'b1; bus.rd = 1'b1;
    idle(1);
    bus.ps2_hit = 1'b0; bus.rd = 1'b0;
    checks++; if ({bus.count, bus.q} !== {5'd1, 8'h33}) begin errors++; $display("FAIL empty_pushpop got cnt %0d q %h want 1 33", bus.count, bus.q); end
    send(8'h34);
    pop1();
    checks++; if ({bus.count, bus.q} !== {5'd1, 8'h34}) begin errors++; $display("FAIL empty_next got cnt %0d q %h want 1 34", bus.count, bus.q); end
    pop1();
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hF0);
    idle(100);
    send(8'h1C);
    checks++; if ({bus.q_ext, bus.q_rel, bus.q} !== {2'b01, 8'h1C}) begin errors++; $display("FAIL tmo_short got %h want 11c", {bus.q_ext, bus.q_rel, bus.q}); end
    pop1();
    send(8'hF0);
    idle(50000);
    send(8'h1C);
    checks++; if ({bus.count, bus.q_ext, bus.q_rel, bus.q} !== {5'd1, 2'b00, 8'h1C}) begin errors++; $display("FAIL tmo_expired got cnt %0d entry %h want cnt 1 entry 01c", bus.count, {bus.q_ext, bus.q_rel, bus.q}); end
    pop1();
  endtask

  task automatic test_typematic();
    logic [9:0] exp_e [$];
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef KBD_FIFO_TYPEMATIC_FILTER_EN
    exp_e = '{{2'b00, 8'h1C}, {2'b01, 8'h1C}, {2'b00, 8'h1C}};
`else
    exp_e = '{{2'b00, 8'h1C}, {2'b00, 8'h1C}, {2'b00, 8'h1C}, {2'b01, 8'h1C}, {2'b00, 8'h1C}};
`endif
    checks++; if (int'(bus.count) != exp_e.size()) begin errors++; $display("FAIL typ_count got %0d want %0d", bus.count, exp_e.size()); end
    foreach (exp_e[i]) begin
      checks++; if ({bus.q_ext, bus.q_rel, bus.q} !== exp_e[i]) begin errors++; $display("FAIL typ_entry%0d got %h want %h", i, {bus.q_ext, bus.q_rel, bus.q}, exp_e[i]); end
      pop1();
    end
  endtask

  initial begin
    bus.ps2_data = 8'h00;
    bus.ps2_hit  = 1'b0;
    bus.rd       = 1'b0;
    bus.ovf_clr  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_prefix();
    test_order();
    test_overflow();
    test_empty_edge();
    test_timeout();
    test_typematic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
